// File: rtl/vram_wr_source.sv
// VRAM write-stream source: forwards the sampler's writes or fills the frame buffer with a
// generated test pattern. A new mode takes effect only at a frame start.
module vram_wr_source #(
    parameter int PIX_BITS  = 2,
    parameter int XBITS     = 8,
    parameter int YBITS     = 8,
    parameter int XRES      = 160,
    parameter int YRES      = 144,
    parameter int CHK_SHIFT = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             mode,
    input  logic                   vsync,
    input  logic                   smp_we,
    input  logic [XBITS+YBITS-1:0] smp_addr,
    input  logic [PIX_BITS-1:0]    smp_data,
    output logic                   wr_we,
    output logic [XBITS+YBITS-1:0] wr_addr,
    output logic [PIX_BITS-1:0]    wr_data,
    output logic [2:0]             cur_mode,
    output logic [7:0]             frame_cnt,
    output logic                   busy,
    output logic                   overrun,
    output logic [1:0]             dbg_state
);

    // Write port semantics: wr_we is a one-cycle write strobe with no back-pressure;
    // wr_addr/wr_data are valid in the same cycle wr_we is high.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [XBITS-1:0] X_LAST = XBITS'(XRES - 1);
    localparam logic [YBITS-1:0] Y_LAST = YBITS'(YRES - 1);
    localparam int S = CHK_SHIFT;

    state_t               state, state_nxt;
    logic                 vs_q;
    logic                 fs;
    logic [XBITS-1:0]     x, x_nxt;
    logic [YBITS-1:0]     y, y_nxt;
    logic [XBITS-1:0]     x_scroll;
    logic [PIX_BITS-1:0]  pat;

    assign fs        = vsync & ~vs_q;
    assign busy      = (state == FILL);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
        end else begin
            state <= state_nxt;
            x     <= x_nxt;
            y     <= y_nxt;
        end
    end

    // A frame start restarts the scan at (0,0); the next state depends on the incoming mode.
    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        y_nxt     = y;
        case (state)
            IDLE, DONE: begin
                if (fs) begin
                    state_nxt = (mode != 3'd0) ? FILL : IDLE;
                    x_nxt     = '0;
                    y_nxt     = '0;
                end
            end
            FILL: begin
                if (fs) begin
                    state_nxt = (mode != 3'd0) ? FILL : IDLE;
                    x_nxt     = '0;
                    y_nxt     = '0;
                end else if (x == X_LAST) begin
                    x_nxt = '0;
                    if (y == Y_LAST) begin
                        state_nxt = DONE;
                        y_nxt     = '0;
                    end else begin
                        y_nxt = y + 1'b1;
                    end
                end else begin
                    x_nxt = x + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                x_nxt     = '0;
                y_nxt     = '0;
            end
        endcase
    end

    always_comb begin
        x_scroll = x + XBITS'(frame_cnt);
        pat      = '0;
        case (cur_mode)
            3'd1:    pat = '1;
            3'd3:    pat = x[S+PIX_BITS-1:S] ^ y[S+PIX_BITS-1:S];
            3'd4:    pat = x[S+PIX_BITS-1:S];
            3'd5:    pat = x_scroll[S+PIX_BITS-1:S] ^ y[S+PIX_BITS-1:S];
            3'd6:    pat = y[YBITS-1 -: PIX_BITS];
            default: pat = '0;
        endcase
    end

    // Output register uses the mode in effect this cycle, so the fs cycle still shows the old mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q      <= 1'b0;
            cur_mode  <= 3'd0;
            frame_cnt <= 8'd0;
            overrun   <= 1'b0;
            wr_we     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            vs_q <= vsync;
            if (fs) begin
                cur_mode  <= mode;
                frame_cnt <= frame_cnt + 8'd1;
                if (state == FILL)
                    overrun <= 1'b1;
            end
            if (cur_mode == 3'd0) begin
                wr_we   <= smp_we;
                wr_addr <= smp_addr;
                wr_data <= smp_data;
            end else if (state == FILL) begin
                wr_we   <= 1'b1;
                wr_addr <= {y, x};
                wr_data <= pat;
            end else begin
                wr_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vram_wr_source.sv
// Directed bench for vram_wr_source: pass-through, pattern fills, overrun restart,
// frame counter wrap and mid-fill reset.
module tb_vram_wr_source;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  mode;
    logic        vsync;
    logic        smp_we;
    logic [15:0] smp_addr;
    logic [1:0]  smp_data;
    logic        wr_we;
    logic [15:0] wr_addr;
    logic [1:0]  wr_data;
    logic [2:0]  cur_mode;
    logic [7:0]  frame_cnt;
    logic        busy;
    logic        overrun;
    logic [1:0]  dbg_state;

    int tests_run = 0;
    int tests_failed = 0;

    logic [1:0] vram [65536];
    int         write_cnt = 0;
    logic [15:0] last_addr = '0;

    vram_wr_source dut (
        .clk(clk), .rst(rst), .mode(mode), .vsync(vsync),
        .smp_we(smp_we), .smp_addr(smp_addr), .smp_data(smp_data),
        .wr_we(wr_we), .wr_addr(wr_addr), .wr_data(wr_data),
        .cur_mode(cur_mode), .frame_cnt(frame_cnt), .busy(busy),
        .overrun(overrun), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_we === 1'b1) begin
            vram[wr_addr] <= wr_data;
            write_cnt     <= write_cnt + 1;
            last_addr     <= wr_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic frame_start();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
    endtask

    task automatic wait_fill_done(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 30000) begin
            tick();
            n++;
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 3'd0; vsync = 1'b0;
        smp_we = 1'b0; smp_addr = '0; smp_data = '0;
        ticks(2);
        rst = 1'b0;
        tests_run++;
        if ({wr_we, wr_addr, wr_data} !== 19'd0) begin
            tests_failed++;
            $display("FAIL reset_wr: we=%b addr=%h data=%0d, required 0/0000/0", wr_we, wr_addr, wr_data);
        end
        tests_run++;
        if (cur_mode !== 3'd0 || frame_cnt !== 8'd0 || busy !== 1'b0 || overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_status: mode=%0d fcnt=%0d busy=%b ovr=%b, required all 0",
                     cur_mode, frame_cnt, busy, overrun);
        end
    endtask

    task automatic test_pass();
        smp_we = 1'b1; smp_addr = 16'h1234; smp_data = 2'd2;
        tick();
        tests_run++;
        if (wr_we !== 1'b1 || wr_addr !== 16'h1234 || wr_data !== 2'd2) begin
            tests_failed++;
            $display("FAIL pass_write: we=%b addr=%h data=%0d, required 1/1234/2", wr_we, wr_addr, wr_data);
        end
        smp_we = 1'b0; smp_addr = 16'h00ff; smp_data = 2'd1;
        tick();
        tests_run++;
        if (wr_we !== 1'b0 || wr_addr !== 16'h00ff) begin
            tests_failed++;
            $display("FAIL pass_idle: we=%b addr=%h, required 0/00ff", wr_we, wr_addr);
        end
    endtask

    task automatic test_checker();
        int start;
        mode = 3'd3;
        start = write_cnt;
        frame_start();
        tests_run++;
        if (cur_mode !== 3'd3 || frame_cnt !== 8'd1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL chk_start: mode=%0d fcnt=%0d busy=%b, required 3/1/1", cur_mode, frame_cnt, busy);
        end
        wait_fill_done("chk");
        tick();
        tests_run++;
        if (write_cnt - start !== 23040) begin
            tests_failed++;
            $display("FAIL chk_count: %0d writes, required 23040", write_cnt - start);
        end
        tests_run++;
        if (wr_we !== 1'b0 || last_addr !== {8'd143, 8'd159}) begin
            tests_failed++;
            $display("FAIL chk_end: we=%b last_addr=%h, required 0/8f9f", wr_we, last_addr);
        end
        tests_run++;
        if (vram[{8'd0, 8'd8}] !== 2'd1 || vram[{8'd8, 8'd8}] !== 2'd0 ||
            vram[{8'd0, 8'd24}] !== 2'd3 || vram[{8'd8, 8'd16}] !== 2'd3) begin
            tests_failed++;
            $display("FAIL chk_pixels: (8,0)=%0d (8,8)=%0d (24,0)=%0d (16,8)=%0d, required 1/0/3/3",
                     vram[{8'd0, 8'd8}], vram[{8'd8, 8'd8}], vram[{8'd0, 8'd24}], vram[{8'd8, 8'd16}]);
        end
    endtask

    task automatic test_scroll_overrun();
        mode = 3'd0;
        frame_start();
        tick();
        mode = 3'd5;
        frame_start();
        ticks(20);
        tests_run++;
        if (frame_cnt !== 8'd3 || vram[{8'd0, 8'd5}] !== 2'd1 || vram[{8'd0, 8'd4}] !== 2'd0 ||
            vram[{8'd0, 8'd13}] !== 2'd2) begin
            tests_failed++;
            $display("FAIL scroll_pixels: fcnt=%0d (5,0)=%0d (4,0)=%0d (13,0)=%0d, required 3/1/0/2",
                     frame_cnt, vram[{8'd0, 8'd5}], vram[{8'd0, 8'd4}], vram[{8'd0, 8'd13}]);
        end
        ticks(980);
        tests_run++;
        if (overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovr_pre: overrun=%b, required 0", overrun);
        end
        frame_start();
        tests_run++;
        if (overrun !== 1'b1 || frame_cnt !== 8'd4) begin
            tests_failed++;
            $display("FAIL ovr_set: overrun=%b fcnt=%0d, required 1/4", overrun, frame_cnt);
        end
        tick();
        tests_run++;
        if (wr_we !== 1'b1 || wr_addr !== 16'h0000 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovr_restart: we=%b addr=%h busy=%b, required 1/0000/1", wr_we, wr_addr, busy);
        end
    endtask

    task automatic test_frame_wrap();
        mode = 3'd0;
        for (int i = 0; i < 251; i++) begin
            frame_start();
            tick();
        end
        tests_run++;
        if (frame_cnt !== 8'd255 || cur_mode !== 3'd0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_255: fcnt=%0d mode=%0d busy=%b, required 255/0/0", frame_cnt, cur_mode, busy);
        end
        frame_start();
        tick();
        tests_run++;
        if (frame_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL wrap_0: fcnt=%0d, required 0", frame_cnt);
        end
    endtask

    task automatic test_mode_change();
        int start;
        mode = 3'd1;
        ticks(5);
        tests_run++;
        if (cur_mode !== 3'd0 || busy !== 1'b0 || wr_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL mode_hold: mode=%0d busy=%b we=%b, required 0/0/0", cur_mode, busy, wr_we);
        end
        start = write_cnt;
        frame_start();
        tests_run++;
        if (cur_mode !== 3'd1 || frame_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL mode1_start: mode=%0d fcnt=%0d, required 1/1", cur_mode, frame_cnt);
        end
        wait_fill_done("mode1");
        tick();
        tests_run++;
        if (write_cnt - start !== 23040 || vram[16'h0000] !== 2'd3 || vram[{8'd143, 8'd159}] !== 2'd3 ||
            vram[{8'd0, 8'd100}] !== 2'd3) begin
            tests_failed++;
            $display("FAIL mode1_fill: writes=%0d (0,0)=%0d (159,143)=%0d (100,0)=%0d, required 23040/3/3/3",
                     write_cnt - start, vram[16'h0000], vram[{8'd143, 8'd159}], vram[{8'd0, 8'd100}]);
        end
        mode = 3'd7;
        frame_start();
        ticks(300);
        tests_run++;
        if (cur_mode !== 3'd7 || frame_cnt !== 8'd2 || busy !== 1'b1 ||
            vram[{8'd0, 8'd100}] !== 2'd0 || vram[{8'd1, 8'd10}] !== 2'd0) begin
            tests_failed++;
            $display("FAIL mode7_fill: mode=%0d fcnt=%0d busy=%b (100,0)=%0d (10,1)=%0d, required 7/2/1/0/0",
                     cur_mode, frame_cnt, busy, vram[{8'd0, 8'd100}], vram[{8'd1, 8'd10}]);
        end
    endtask

    task automatic test_bars_gradient();
        mode = 3'd4;
        frame_start();
        ticks(40);
        tests_run++;
        if (vram[{8'd0, 8'd8}] !== 2'd1 || vram[{8'd0, 8'd24}] !== 2'd3 || vram[{8'd0, 8'd16}] !== 2'd2) begin
            tests_failed++;
            $display("FAIL bars: (8,0)=%0d (24,0)=%0d (16,0)=%0d, required 1/3/2",
                     vram[{8'd0, 8'd8}], vram[{8'd0, 8'd24}], vram[{8'd0, 8'd16}]);
        end
        mode = 3'd6;
        frame_start();
        ticks(64 * 160 + 200);
        tests_run++;
        if (vram[{8'd64, 8'd0}] !== 2'd1 || vram[{8'd65, 8'd3}] !== 2'd1 || vram[{8'd0, 8'd24}] !== 2'd0) begin
            tests_failed++;
            $display("FAIL gradient: (0,64)=%0d (3,65)=%0d (24,0)=%0d, required 1/1/0",
                     vram[{8'd64, 8'd0}], vram[{8'd65, 8'd3}], vram[{8'd0, 8'd24}]);
        end
    endtask

    task automatic test_reset_mid_fill();
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_pre: busy=%b, required 1", busy);
        end
        rst = 1'b1;
        tick();
        tests_run++;
        if (wr_we !== 1'b0 || busy !== 1'b0 || frame_cnt !== 8'd0 || overrun !== 1'b0 || cur_mode !== 3'd0) begin
            tests_failed++;
            $display("FAIL rst_mid: we=%b busy=%b fcnt=%0d ovr=%b mode=%0d, required all 0",
                     wr_we, busy, frame_cnt, overrun, cur_mode);
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if (wr_we !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_after: we=%b busy=%b, required 0/0", wr_we, busy);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_checker();
        test_scroll_overrun();
        test_frame_wrap();
        test_mode_change();
        test_bars_gradient();
        test_reset_mid_fill();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
